// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, variable-latency imem request, IF/ID register.
// Latency: zero-wait memory delivers the word fetched in cycle N into IF/ID on edge N+1.
// Backpressure: StallF parks a returning word in HOLD; StallD freezes IF/ID; no request while holding.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PCin,
  input  logic        RedirectD,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        ImemValid,
  input  logic [31:0] ImemRdata,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic        FetchBusy
);

  // FETCH: request outstanding; HOLD: word parked during a stall;
  // DISCARD: outstanding request belongs to a squashed path.
  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_buf_q, instr_buf_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic        ifid_vld_q, ifid_vld_d;

  logic        redirect;
  logic        deliver;
  logic [31:0] instr_f;

  // A redirect is only honoured when the PC is allowed to move.
  assign redirect  = RedirectD && !StallF;
  assign deliver   = !StallF && (((state_q == FETCH) && ImemValid) || (state_q == HOLD));
  assign instr_f   = (state_q == HOLD) ? instr_buf_q : ImemRdata;

  assign ImemReq   = rst_n && (state_q != HOLD);
  assign ImemAddr  = pc_q;
  assign PCF       = pc_q;
  assign PCPlus4F  = pc_q + 32'd4;
  assign FetchBusy = ImemReq && !ImemValid;
  assign InstrD    = ifid_instr_q;
  assign PCPlus4D  = ifid_pc4_q;
  assign ValidD    = ifid_vld_q;

  // Next-state logic for the fetch FSM, PC, parked word and pending redirect target.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_buf_d = instr_buf_q;
    pend_pc_d   = pend_pc_q;
    case (state_q)
      FETCH: begin
        if (ImemValid) begin
          if (!StallF) begin
            pc_d = PCin;
          end else begin
            instr_buf_d = ImemRdata;
            state_d     = HOLD;
          end
        end else if (redirect) begin
          pend_pc_d = PCin;
          state_d   = DISCARD;
        end
      end
      HOLD: begin
        if (!StallF) begin
          pc_d    = PCin;
          state_d = FETCH;
        end
      end
      DISCARD: begin
        // Newest redirect target wins, including one arriving with the stale data.
        if (redirect) begin
          pend_pc_d = PCin;
        end
        if (ImemValid) begin
          pc_d    = redirect ? PCin : pend_pc_q;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // IF/ID next value: flush beats stall beats load; no delivery means a bubble.
  always_comb begin
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_vld_d   = ifid_vld_q;
    if (FlushD) begin
      ifid_instr_d = NOP_INSTR;
      ifid_pc4_d   = 32'd0;
      ifid_vld_d   = 1'b0;
    end else if (StallD) begin
      ifid_instr_d = ifid_instr_q;
    end else if (deliver) begin
      ifid_instr_d = instr_f;
      ifid_pc4_d   = PCPlus4F;
      ifid_vld_d   = 1'b1;
    end else begin
      ifid_instr_d = NOP_INSTR;
      ifid_pc4_d   = 32'd0;
      ifid_vld_d   = 1'b0;
    end
  end

  // State registers with synchronous reset; reset abandons any in-flight fetch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      instr_buf_q  <= 32'd0;
      pend_pc_q    <= 32'd0;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc4_q   <= 32'd0;
      ifid_vld_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_buf_q  <= instr_buf_d;
      pend_pc_q    <= pend_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_vld_q   <= ifid_vld_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized hazards against a reference model.
// The bench plays the memory (configurable wait count) and the next-PC mux.
// A second instance with RESET_PC = 0xFFFFFFFC covers PC wrap.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC   = 32'h0000_0000;
  localparam logic [31:0] W_RST_PC = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, RedirectD, StallF, StallD, FlushD, ImemValid;
  logic [31:0] PCin, ImemRdata, pcin_w;

  logic        ImemReq, ValidD, FetchBusy;
  logic [31:0] ImemAddr, PCF, PCPlus4F, InstrD, PCPlus4D;
  logic        w_ImemReq, w_ValidD, w_FetchBusy;
  logic [31:0] w_ImemAddr, w_PCF, w_PCPlus4F, w_InstrD, w_PCPlus4D;

  fetch_stage u_dut (
    .clk(clk), .rst_n(rst_n), .PCin(PCin), .RedirectD(RedirectD), .StallF(StallF),
    .StallD(StallD), .FlushD(FlushD), .ImemValid(ImemValid), .ImemRdata(ImemRdata),
    .ImemReq(ImemReq), .ImemAddr(ImemAddr), .PCF(PCF), .PCPlus4F(PCPlus4F),
    .InstrD(InstrD), .PCPlus4D(PCPlus4D), .ValidD(ValidD), .FetchBusy(FetchBusy)
  );

  fetch_stage #(.RESET_PC(W_RST_PC)) u_wrap (
    .clk(clk), .rst_n(rst_n), .PCin(pcin_w), .RedirectD(RedirectD), .StallF(StallF),
    .StallD(StallD), .FlushD(FlushD), .ImemValid(ImemValid), .ImemRdata(ImemRdata),
    .ImemReq(w_ImemReq), .ImemAddr(w_ImemAddr), .PCF(w_PCF), .PCPlus4F(w_PCPlus4F),
    .InstrD(w_InstrD), .PCPlus4D(w_PCPlus4D), .ValidD(w_ValidD), .FetchBusy(w_FetchBusy)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Hazard-unit contract: ID may only stall together with IF.
  always @(posedge clk) begin
    assert (!(StallD && !StallF)) else $error("FAIL contract: StallD without StallF");
  end

  // Reference model: PC, a parked word (if any), a squashed-request flag with its target.
  logic [31:0] m_pc, m_hold_word, m_target, m_instrD, m_pc4D;
  bit          m_hold, m_squash, m_validD;
  int          m_wait, mem_wait, busy_cnt;

  // Stimulus knobs
  bit          s_rst_n, s_stallF, s_stallD, s_flushD, s_redir, use_force, rand_data;
  logic [31:0] s_tgt, force_word;

  task automatic model_update();
    bit          redir, req, dlv;
    logic [31:0] word;
    if (!rst_n) begin
      m_pc = RST_PC; m_hold = 0; m_squash = 0; m_target = 0; m_hold_word = 0;
      m_instrD = 0; m_pc4D = 0; m_validD = 0; m_wait = 0;
    end else begin
      redir = RedirectD && !StallF;
      req   = !m_hold;
      dlv   = !StallF && (m_hold || (!m_squash && ImemValid));
      word  = m_hold ? m_hold_word : ImemRdata;
      if (FlushD) begin
        m_instrD = 0; m_pc4D = 0; m_validD = 0;
      end else if (!StallD) begin
        if (dlv) begin
          m_instrD = word; m_pc4D = m_pc + 32'd4; m_validD = 1;
        end else begin
          m_instrD = 0; m_pc4D = 0; m_validD = 0;
        end
      end
      if (!req || ImemValid) m_wait = 0;
      else m_wait++;
      if (m_hold) begin
        if (!StallF) begin m_pc = PCin; m_hold = 0; end
      end else if (m_squash) begin
        if (redir) m_target = PCin;
        if (ImemValid) begin m_pc = m_target; m_squash = 0; end
      end else if (ImemValid) begin
        if (!StallF) m_pc = PCin;
        else begin m_hold = 1; m_hold_word = ImemRdata; end
      end else if (redir) begin
        m_target = PCin; m_squash = 1;
      end
    end
  endtask

  // One clock: drive inputs at the falling edge, check just after, then advance the model.
  task automatic cycle();
    bit req;
    rst_n     = s_rst_n;
    StallF    = s_stallF;
    StallD    = s_stallD;
    FlushD    = s_flushD;
    RedirectD = s_redir;
    req       = s_rst_n && !m_hold;
    ImemValid = req && (m_wait >= mem_wait);
    ImemRdata = use_force ? force_word : (rand_data ? $urandom : (m_pc | 32'hA000_0000));
    PCin      = s_redir ? s_tgt : (m_pc + 32'd4);
    #1;
    check("PCF", PCF, m_pc);
    check("ImemAddr", ImemAddr, m_pc);
    check("PCPlus4F", PCPlus4F, m_pc + 32'd4);
    check("ImemReq", 32'(ImemReq), 32'(req));
    check("FetchBusy", 32'(FetchBusy), 32'(req && !ImemValid));
    check("InstrD", InstrD, m_instrD);
    check("PCPlus4D", PCPlus4D, m_pc4D);
    check("ValidD", 32'(ValidD), 32'(m_validD));
    if (FetchBusy === 1'b1) busy_cnt++;
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] w_start, p0, hold_pc;
    int          cnt;
    s_rst_n = 0; s_stallF = 0; s_stallD = 0; s_flushD = 0; s_redir = 0; s_tgt = 0;
    use_force = 0; force_word = 0; rand_data = 0; mem_wait = 0; busy_cnt = 0;
    rst_n = 0; StallF = 0; StallD = 0; FlushD = 0; RedirectD = 0;
    ImemValid = 0; ImemRdata = 0; PCin = 0; pcin_w = 0;
    repeat (2) @(posedge clk);
    model_update();
    @(negedge clk);

    // Reset state of both instances
    w_start = W_RST_PC;
    check("rst_PCF", PCF, RST_PC);
    check("rst_ValidD", 32'(ValidD), 32'd0);
    check("rst_InstrD", InstrD, 32'd0);
    check("rst_ImemReq", 32'(ImemReq), 32'd0);
    check("rst_wrap_PCF", w_PCF, w_start);
    check("rst_wrap_PCPlus4F", w_PCPlus4F, w_start + 32'd4);

    // Zero-wait memory: one instruction per cycle
    s_rst_n = 1; mem_wait = 0; pcin_w = w_start + 32'd4;
    cycle();
    check("zw_PCF1", PCF, 32'h4);
    check("zw_InstrD", InstrD, 32'hA000_0000);
    check("zw_ValidD", 32'(ValidD), 32'd1);
    check("zw_PCPlus4D", PCPlus4D, 32'h4);
    check("wrap_second_addr", w_ImemAddr, 32'h0);
    cycle();
    check("zw_PCF2", PCF, 32'h8);

    // Latency 3: two busy cycles per fetch, PC advances every third cycle
    mem_wait = 2; busy_cnt = 0; p0 = PCF;
    for (int k = 1; k <= 2; k++) begin
      repeat (3) cycle();
      check("lat3_PCF", PCF, p0 + 32'(4 * k));
      check("lat3_ValidD", 32'(ValidD), 32'd1);
    end
    check("lat3_busy", 32'(busy_cnt), 32'd4);

    // Stall when the word returns: park in HOLD, deliver exactly once after release
    mem_wait = 0; s_stallF = 1; s_stallD = 1; use_force = 1; force_word = 32'h1234_5678;
    hold_pc = PCF;
    cycle();
    use_force = 0;
    check("hold_req", 32'(ImemReq), 32'd0);
    repeat (3) cycle();
    check("hold_req_still", 32'(ImemReq), 32'd0);
    check("hold_PCF", PCF, hold_pc);
    s_stallF = 0; s_stallD = 0; cnt = 0;
    repeat (3) begin
      cycle();
      if (InstrD === 32'h1234_5678 && ValidD === 1'b1) cnt++;
    end
    check("hold_once", 32'(cnt), 32'd1);
    check("hold_no_refetch", PCF, hold_pc + 32'd12);

    // Redirect while waiting (latency 4): stale word dropped, then fetch from target
    mem_wait = 0; s_redir = 1; s_tgt = 32'h20;
    cycle();
    s_redir = 0;
    check("redir_PCF20", PCF, 32'h20);
    mem_wait = 3; cnt = 0;
    cycle(); cnt += 32'(ValidD);
    s_redir = 1; s_tgt = 32'h100;
    cycle(); cnt += 32'(ValidD);
    s_redir = 0;
    check("discard_addr_stable", ImemAddr, 32'h20);
    repeat (2) begin cycle(); cnt += 32'(ValidD); end
    check("discard_next_addr", ImemAddr, 32'h100);
    check("discard_no_deliver", 32'(cnt), 32'd0);
    cnt = 0;
    s_redir = 1; s_tgt = 32'h300;
    cycle(); cnt += 32'(ValidD);
    s_tgt = 32'h200;
    cycle(); cnt += 32'(ValidD);
    s_redir = 0;
    repeat (2) begin cycle(); cnt += 32'(ValidD); end
    check("discard_newest_wins", ImemAddr, 32'h200);
    check("discard2_no_deliver", 32'(cnt), 32'd0);

    // Redirect with flush, then flush beating stall
    mem_wait = 0;
    cycle();
    s_redir = 1; s_tgt = 32'h40; s_flushD = 1;
    cycle();
    s_redir = 0; s_flushD = 0;
    check("flush_InstrD", InstrD, 32'd0);
    check("flush_ValidD", 32'(ValidD), 32'd0);
    check("flush_PCF", PCF, 32'h40);
    cycle();
    check("load_ValidD", 32'(ValidD), 32'd1);
    s_flushD = 1; s_stallD = 1; s_stallF = 1;
    cycle();
    s_flushD = 0; s_stallD = 0;
    check("flush_over_stall_V", 32'(ValidD), 32'd0);
    check("flush_over_stall_I", InstrD, 32'd0);

    // Reset while parked in HOLD
    cycle();
    check("pre_rst_hold_req", 32'(ImemReq), 32'd0);
    s_rst_n = 0;
    cycle();
    s_rst_n = 1; s_stallF = 0;
    check("rst_hold_PCF", PCF, RST_PC);
    check("rst_hold_ValidD", 32'(ValidD), 32'd0);
    cycle();

    // Randomized hazards, redirects, latencies and occasional resets
    rand_data = 1;
    repeat (2000) begin
      s_stallF = ($urandom_range(0, 3) == 0);
      s_stallD = s_stallF && ($urandom_range(0, 1) == 1);
      s_flushD = ($urandom_range(0, 9) == 0);
      s_redir  = ($urandom_range(0, 6) == 0);
      s_tgt    = $urandom & 32'hFFFF_FFFC;
      s_rst_n  = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 15) == 0) mem_wait = $urandom_range(0, 3);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
